alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Shares the single combinational Alu instance between NUM_REQ requesters, such as the execute stage, the address generator and the debug port.
- Round-robin arbitration with a valid/ready request handshake.
- Registers the winner's operands, captures the result and flags, and returns them over a valid/ready response handshake.
- At most one operation is in flight at any time.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
WORD_WIDTH, `CPU_WORD_WIDTH, operand/result width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  NUM_REQ  per-requester operation request
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  NUM_REQ*WORD_WIDTH  operand A; slice i belongs to requester i
req_b  in  NUM_REQ*WORD_WIDTH  operand B / shift count
req_op  in  NUM_REQ*$bits(pkg_cpu ALU op)  ALU operation
req_flags_in  in  NUM_REQ*4  flags in; carry is used by Alu_Rlc/Alu_Rrc
resp_valid  out  NUM_REQ  result valid for the owning requester
resp_ready  in  NUM_REQ  per-requester result accept
resp_out  out  WORD_WIDTH  registered ALU result, shared by all requesters
resp_flags  out  4  registered flags_out, indexed FlagZ/C/N/V
busy  out  1  high whenever state != IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (asynchronous) forces:
  - state = IDLE; all outputs 0; operand and result registers 0.
  - rr_ptr = NUM_REQ-1, so requester 0 wins first.
- Arbitration: winner is the first i with req_valid[i], scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
- req_ready[winner] is combinational and asserted only in IDLE, or in RESP in the same cycle as the response handshake.
- Request handshake (req_valid & req_ready) on edge E0:
  - Latches a/b/op/flags_in into alu_in registers.
  - owner <= winner; rr_ptr <= winner; next state = EXEC.
- EXEC: Alu evaluates the registered inputs. On edge E1, alu_out.out and flags_out are captured into resp_out/resp_flags; next state = RESP.
- RESP: resp_valid[owner] = 1, all other bits 0. resp_out and resp_flags are held stable until the handshake.
- On resp_valid & resp_ready[owner]:
  - If any req_valid is high: accept the RR winner in the same cycle; next state = EXEC. This is back-to-back operation, giving 1 op per 2 cycles.
  - Otherwise: next state = IDLE.
  - resp_valid drops after the edge; resp_out is held until the next capture.
- Latency: response visible one cycle after the accept edge. Minimum accept-to-response-handshake is 2 edges.
- Fairness: with all requesters valid continuously, grants rotate 0,1,..,NUM_REQ-1,0.
- The sole valid requester may be re-granted back-to-back, including the current owner.
- Deasserting req_valid while not granted is legal. Operands are sampled only on the accept edge.
- resp_ready high before resp_valid is legal, and the handshake then completes immediately in RESP.
- resp_ready[j] for j != owner is ignored.
- Reset mid-EXEC or mid-RESP: the in-flight operation is discarded, no response is issued, and rr_ptr is reset.
- Flags are passed through from Alu unmodified:
  - Sub semantics: C=1 means no borrow.
  - Unsigned less-than is C==0; signed less-than is N!=V.

Decomposition:
- pkg_cpu gains:
  - enum StateAluArb {IDLE, EXEC, RESP}
  - localparam ALU_ARB_MAX_REQ = 4
  - function rr_pick(valid, ptr), returning the winner index plus an any-valid bit
- Reuses the existing StrcInAlu/StrcOutAlu and the ALU op enum.
- Sub-modules:
  - One internal Alu instance.
  - One sub-module, alu_arb_rr_picker: combinational round-robin winner select, reusable by future shared-resource arbiters.

Test Plan:
1. Reset: rst=1 for 3 cycles with all req_valid=1 -> req_ready=0, resp_valid=0, busy=0. After release, the first grant goes to req 0.
2. Single op, WORD_WIDTH=8: req0 Alu_Sub a=8'h05 b=8'h05 -> req_ready[0]=1 in the accept cycle; resp_valid[0]=1 one cycle later with resp_out=8'h00, Z=1, C=1.
3. Contention: both valid continuously; req0 Sub 8'h03-8'h05, req1 Alu_Rol 8'h81 by 8'h01 -> grants alternate 0,1,0,1. Req0 gets out=8'hFE, C=0, N=1; req1 gets out=8'h03.
4. Backpressure: resp_ready[0]=0 for 5 cycles with req1 pending -> resp_valid[0] stays 1, resp_out stable, req_ready=0. On release, req1 is accepted in the same cycle and resp_valid[1] follows one cycle later.
5. Signed flags: Sub 8'h80-8'h01 -> out=8'h7F, N=0, V=1, C=1, Z=0; Alu_Rlc 8'h80 with carry-in 1 -> result per the Alu definition, forwarded unmodified.
6. Reset mid-EXEC: assert rst the cycle after accepting req1 -> no resp_valid ever issued for that op; the next grant goes to req 0.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared CPU datapath types: ALU op encoding, ALU port structs, and the
// round-robin helper used by shared-resource arbiters.
`ifndef CPU_WORD_WIDTH
`define CPU_WORD_WIDTH 8
`endif

package alu_share_arbiter_pkg;

    localparam int CPU_WORD_WIDTH  = `CPU_WORD_WIDTH;
    localparam int ALU_ARB_MAX_REQ = 4;
    localparam int ARB_IDX_W       = $clog2(ALU_ARB_MAX_REQ);

    localparam int FlagZ = 0;
    localparam int FlagC = 1;
    localparam int FlagN = 2;
    localparam int FlagV = 3;

    typedef enum logic [3:0] {
        Alu_Add = 4'd0,
        Alu_Sub = 4'd1,
        Alu_And = 4'd2,
        Alu_Or  = 4'd3,
        Alu_Xor = 4'd4,
        Alu_Shl = 4'd5,
        Alu_Shr = 4'd6,
        Alu_Rol = 4'd7,
        Alu_Ror = 4'd8,
        Alu_Rlc = 4'd9,
        Alu_Rrc = 4'd10
    } AluOp;

    localparam int ALU_OP_W = $bits(AluOp);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } StateAluArb;

    typedef struct packed {
        AluOp                      op;
        logic [CPU_WORD_WIDTH-1:0] a;
        logic [CPU_WORD_WIDTH-1:0] b;
        logic [3:0]                flags_in;
    } StrcInAlu;

    typedef struct packed {
        logic [CPU_WORD_WIDTH-1:0] out;
        logic [3:0]                flags_out;
    } StrcOutAlu;

    typedef struct packed {
        logic                 any;
        logic [ARB_IDX_W-1:0] idx;
    } RrPick;

    // Scan ptr+1, ptr+2, ... modulo num_req; descending k lets the nearest valid win.
    function automatic RrPick rr_pick(input logic [ALU_ARB_MAX_REQ-1:0] valid,
                                      input logic [ARB_IDX_W-1:0]       ptr,
                                      input int                         num_req);
        RrPick r;
        int    idx;
        r = '0;
        for (int k = ALU_ARB_MAX_REQ; k >= 1; k--) begin
            if (k <= num_req) begin
                idx = (int'(ptr) + k) % num_req;
                if (valid[idx[ARB_IDX_W-1:0]]) begin
                    r.any = 1'b1;
                    r.idx = idx[ARB_IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational CPU ALU; flags follow the FlagZ/C/N/V indices, with
// C meaning "no borrow" on subtraction.
module Alu
    import alu_share_arbiter_pkg::*;
(
    input  StrcInAlu  in_i,
    output StrcOutAlu out_o
);

    localparam int              W     = CPU_WORD_WIDTH;
    localparam logic [W-1:0]    W_VAL = W'(W);

    logic [W:0]   sum;
    logic [W:0]   dif;
    logic [W-1:0] s;
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         cin;
    logic [2:0]   unused_flags;

    assign cin          = in_i.flags_in[FlagC];
    assign unused_flags = {in_i.flags_in[FlagZ], in_i.flags_in[FlagN], in_i.flags_in[FlagV]};
    assign sum          = {1'b0, in_i.a} + {1'b0, in_i.b};
    assign dif          = {1'b0, in_i.a} - {1'b0, in_i.b};
    assign s            = in_i.b % W_VAL;

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (in_i.op)
            Alu_Add: begin
                res = sum[W-1:0];
                c   = sum[W];
                v   = (in_i.a[W-1] == in_i.b[W-1]) && (sum[W-1] != in_i.a[W-1]);
            end
            Alu_Sub: begin
                res = dif[W-1:0];
                c   = ~dif[W];
                v   = (in_i.a[W-1] != in_i.b[W-1]) && (dif[W-1] != in_i.a[W-1]);
            end
            Alu_And: res = in_i.a & in_i.b;
            Alu_Or:  res = in_i.a | in_i.b;
            Alu_Xor: res = in_i.a ^ in_i.b;
            Alu_Shl: res = (in_i.b >= W_VAL) ? '0 : (in_i.a << in_i.b);
            Alu_Shr: res = (in_i.b >= W_VAL) ? '0 : (in_i.a >> in_i.b);
            Alu_Rol: res = (in_i.a << s) | (in_i.a >> (W_VAL - s));
            Alu_Ror: res = (in_i.a >> s) | (in_i.a << (W_VAL - s));
            Alu_Rlc: begin
                res = {in_i.a[W-2:0], cin};
                c   = in_i.a[W-1];
            end
            Alu_Rrc: begin
                res = {cin, in_i.a[W-1:1]};
                c   = in_i.a[0];
            end
            default: res = '0;
        endcase
    end

    always_comb begin
        out_o                  = '0;
        out_o.out              = res;
        out_o.flags_out[FlagZ] = (res == '0);
        out_o.flags_out[FlagC] = c;
        out_o.flags_out[FlagN] = res[W-1];
        out_o.flags_out[FlagV] = v;
    end

endmodule

// File: rtl/alu_arb_rr_picker.sv
// Combinational round-robin winner select for up to ALU_ARB_MAX_REQ requesters.
module alu_arb_rr_picker
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]   valid_i,
    input  logic [ARB_IDX_W-1:0] ptr_i,
    output logic [ARB_IDX_W-1:0] winner_o,
    output logic                 any_o
);

    logic [ALU_ARB_MAX_REQ-1:0] valid_ext;
    RrPick                      pick;

    assign valid_ext = ALU_ARB_MAX_REQ'(valid_i);
    assign pick      = rr_pick(valid_ext, ptr_i, NUM_REQ);
    assign winner_o  = pick.idx;
    assign any_o     = pick.any;

endmodule

// File: rtl/alu_share_arbiter.sv
// Time-shares one ALU between NUM_REQ requesters: round-robin accept,
// one op in flight, registered result returned to the owning requester.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int WORD_WIDTH = CPU_WORD_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WORD_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*ALU_OP_W-1:0]   req_op,
    input  logic [NUM_REQ*4-1:0]          req_flags_in,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [WORD_WIDTH-1:0]         resp_out,
    output logic [3:0]                    resp_flags,
    output logic                          busy
);

    StateAluArb           state_q, state_d;
    logic [ARB_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ARB_IDX_W-1:0] owner_q, owner_d;
    StrcInAlu             alu_in_q, alu_in_d;
    logic [WORD_WIDTH-1:0] resp_out_q, resp_out_d;
    logic [3:0]           resp_flags_q, resp_flags_d;

    logic [ARB_IDX_W-1:0] winner;
    logic                 any_valid;
    logic                 owner_ready;
    logic                 resp_hs;
    logic                 accept;
    StrcInAlu             win_in;
    StrcOutAlu            alu_out;

    alu_arb_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .valid_i  (req_valid),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .any_o    (any_valid)
    );

    Alu u_alu (
        .in_i  (alu_in_q),
        .out_o (alu_out)
    );

    always_comb begin
        win_in      = '0;
        owner_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == ARB_IDX_W'(i)) begin
                win_in.a        = req_a[i*WORD_WIDTH +: WORD_WIDTH];
                win_in.b        = req_b[i*WORD_WIDTH +: WORD_WIDTH];
                win_in.op       = AluOp'(req_op[i*ALU_OP_W +: ALU_OP_W]);
                win_in.flags_in = req_flags_in[i*4 +: 4];
            end
            if (owner_q == ARB_IDX_W'(i)) owner_ready = resp_ready[i];
        end
    end

    // A completing response frees the ALU in the same cycle, so a new accept can overlap it.
    assign resp_hs = (state_q == RESP) && owner_ready;
    assign accept  = any_valid && !rst && ((state_q == IDLE) || resp_hs);
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        owner_d      = owner_q;
        alu_in_d     = alu_in_q;
        resp_out_d   = resp_out_q;
        resp_flags_d = resp_flags_q;
        req_ready    = '0;
        resp_valid   = '0;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: begin
                resp_out_d   = alu_out.out;
                resp_flags_d = alu_out.flags_out;
                state_d      = RESP;
            end
            RESP: begin
                for (int i = 0; i < NUM_REQ; i++)
                    resp_valid[i] = (owner_q == ARB_IDX_W'(i));
                if (resp_hs) state_d = accept ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            alu_in_d = win_in;
            owner_d  = winner;
            rr_ptr_d = winner;
            for (int i = 0; i < NUM_REQ; i++)
                req_ready[i] = (winner == ARB_IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= ARB_IDX_W'(NUM_REQ - 1);
            owner_q      <= '0;
            alu_in_q     <= '0;
            resp_out_q   <= '0;
            resp_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner_q      <= owner_d;
            alu_in_q     <= alu_in_d;
            resp_out_q   <= resp_out_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    assign resp_out   = resp_out_q;
    assign resp_flags = resp_flags_q;

endmodule
